// File: rtl/waste_pkg.sv
// rtl/waste_pkg.sv - shared types and constants for the waste-bin level sensing blocks
package waste_pkg;

    localparam int CAP_W = 8;
    localparam logic [CAP_W-1:0] CAP_FULL = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        CONVERT,
        OUTPUT
    } state_t;

endpackage

// File: rtl/level_avg4.sv
// rtl/level_avg4.sv - 4-sample moving average of fill capacity with first-sample preload
module level_avg4
    import waste_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CAP_W-1:0] i_raw,
    output logic [CAP_W-1:0] o_avg,
    output logic             o_primed
);

    logic [CAP_W-1:0] r_hist [4];
    logic [CAP_W-1:0] w_next [4];
    logic [CAP_W+1:0] w_sum;
    logic [CAP_W-1:0] r_avg;
    logic             r_primed;

    // Entry 0 is the newest sample; an unprimed history is flooded with the first sample.
    always_comb begin
        w_next[0] = i_raw;
        for (int i = 1; i < 4; i++) begin
            w_next[i] = r_primed ? r_hist[i-1] : i_raw;
        end
        w_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum = w_sum + {2'b00, w_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_primed <= 1'b0;
            r_avg    <= '0;
        end else if (i_load) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= w_next[i];
            end
            r_primed <= 1'b1;
            r_avg    <= w_sum[CAP_W+1:2];
        end
    end

    assign o_avg    = r_avg;
    assign o_primed = r_primed;

endmodule

// File: rtl/bin_level_sensor.sv
// rtl/bin_level_sensor.sv - ultrasonic trigger/echo timing front end producing an averaged bin fill level
module bin_level_sensor
    import waste_pkg::*;
#(
    parameter int TRIG_CYCLES     = 500,
    parameter int PERIOD_CYCLES   = 3000000,
    parameter int WAIT_MAX_CYCLES = 50000,
    parameter int ECHO_MAX_CYCLES = 1500000,
    parameter int ECHO_SHIFT      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic [CAP_W-1:0] bin_cap,
    output logic             cap_valid,
    output logic             sensor_fault
);

    state_t           r_state;
    logic             r_echo_meta;
    logic             r_echo_s;
    logic [31:0]      r_cnt;
    logic [31:0]      r_per;
    logic [23:0]      r_echo_cnt;
    logic             r_trig;
    logic             r_cap_valid;
    logic             r_fault;

    logic [23:0]      w_echo_inc;
    logic [23:0]      w_shifted;
    logic [CAP_W-1:0] w_dist;
    logic [CAP_W-1:0] w_raw;
    logic             w_primed;
    logic             w_period_done;
    logic             w_load;

    assign w_echo_inc    = (&r_echo_cnt) ? r_echo_cnt : r_echo_cnt + 24'd1;
    assign w_shifted     = r_echo_cnt >> ECHO_SHIFT;
    assign w_dist        = (|w_shifted[23:CAP_W]) ? CAP_FULL : w_shifted[CAP_W-1:0];
    assign w_raw         = CAP_FULL - w_dist;
    // Counter reaches PERIOD_CYCLES on this edge, so the next trigger lands exactly one period later.
    assign w_period_done = (r_per >= 32'(PERIOD_CYCLES - 1));
    assign w_load        = (r_state == CONVERT);

    level_avg4 u_avg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_raw    (w_raw),
        .o_avg    (bin_cap),
        .o_primed (w_primed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_per       <= '0;
            r_echo_cnt  <= '0;
            r_trig      <= 1'b0;
            r_cap_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
            r_cap_valid <= 1'b0;
            if (r_per < 32'(PERIOD_CYCLES)) begin
                r_per <= r_per + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (enable && (w_period_done || !w_primed)) begin
                        r_state <= TRIG;
                        r_trig  <= 1'b1;
                        r_cnt   <= '0;
                        r_per   <= '0;
                    end
                end
                TRIG: begin
                    if (r_cnt == 32'(TRIG_CYCLES - 1)) begin
                        r_trig  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                WAIT_RISE: begin
                    // The rise cycle itself is the first echo-high cycle counted.
                    if (r_echo_s) begin
                        r_echo_cnt <= 24'd1;
                        r_state    <= MEASURE;
                    end else if (r_cnt >= 32'(WAIT_MAX_CYCLES)) begin
                        r_fault <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                MEASURE: begin
                    if (!r_echo_s) begin
                        r_state <= CONVERT;
                    end else if (w_echo_inc >= 24'(ECHO_MAX_CYCLES)) begin
                        r_echo_cnt <= w_echo_inc;
                        r_fault    <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_echo_cnt <= w_echo_inc;
                    end
                end
                CONVERT: begin
                    r_cap_valid <= 1'b1;
                    r_fault     <= 1'b0;
                    r_state     <= OUTPUT;
                end
                OUTPUT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trig         = r_trig;
    assign cap_valid    = r_cap_valid;
    assign sensor_fault = r_fault;

endmodule

// File: tb/tb_bin_level_sensor.sv
// tb/tb_bin_level_sensor.sv - self-checking bench for bin_level_sensor
module tb_bin_level_sensor;

    localparam int TRIG  = 4;
    localparam int PER   = 400;
    localparam int WMAX  = 20;
    localparam int EMAX  = 300;
    localparam int SHIFT = 0;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       enable = 1'b0;
    logic       echo   = 1'b0;
    logic       trig;
    logic [7:0] bin_cap;
    logic       cap_valid;
    logic       sensor_fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_hist [4];
    bit m_primed = 1'b0;
    int m_q [$];
    int m_cap    = 0;
    bit prev_cv  = 1'b0;
    bit rst_seen = 1'b0;

    bin_level_sensor #(
        .TRIG_CYCLES     (TRIG),
        .PERIOD_CYCLES   (PER),
        .WAIT_MAX_CYCLES (WMAX),
        .ECHO_MAX_CYCLES (EMAX),
        .ECHO_SHIFT      (SHIFT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .bin_cap      (bin_cap),
        .cap_valid    (cap_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Fill level of one echo lasting 'width' cycles, folded into a 4-deep average.
    task automatic model_sample(input int width);
        int d;
        int raw;
        int sum;
        d = width >> SHIFT;
        if (d > 255) d = 255;
        raw = 255 - d;
        if (!m_primed) begin
            for (int i = 0; i < 4; i++) m_hist[i] = raw;
            m_primed = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = raw;
        end
        sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        m_q.push_back(sum / 4);
    endtask

    always @(posedge clk) begin
        rst_seen = rst;
        #2;
        if (rst_seen) begin
            m_cap    = 0;
            m_primed = 1'b0;
            m_q.delete();
        end
        if (cap_valid) begin
            if (m_q.size() == 0) chk("unexpected_cap_valid", 1, 0);
            else m_cap = m_q.pop_front();
            chk("fault_on_valid", int'(sensor_fault), 0);
            chk("cap_valid_width", int'(prev_cv), 0);
        end
        chk("bin_cap_track", int'(bin_cap), m_cap);
        prev_cv = cap_valid;
    end

    task automatic wait_trig_rise(output int rc);
        int n;
        n = 0;
        @(negedge clk);
        while (!trig && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!trig) chk("trig_rise_timeout", 0, 1);
        rc = cyc;
    endtask

    task automatic trig_len(output int len);
        len = 1;
        @(negedge clk);
        while (trig && len < 50) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_echo(input int dly, input int width, output int fall_cyc);
        repeat (dly) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_cap(output int vc);
        int n;
        n = 0;
        @(negedge clk);
        while (!cap_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!cap_valid) chk("cap_valid_timeout", 0, 1);
        vc = cyc;
    endtask

    task automatic wait_fault(output int fcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!sensor_fault && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!sensor_fault) chk("fault_timeout", 0, 1);
        fcyc = cyc;
    endtask

    initial begin
        int r_prev;
        int r_now;
        int len;
        int fc;
        int vc;
        int hi;

        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_bin_cap", int'(bin_cap), 0);
        chk("rst_cap_valid", int'(cap_valid), 0);
        chk("rst_fault", int'(sensor_fault), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("rst_hold_trig", int'(trig), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("trig_after_rst", int'(trig), 1);
        r_prev = cyc;
        trig_len(len);
        chk("trig_len_1", len, 4);
        model_sample(55);
        pulse_echo(10, 55, fc);
        wait_cap(vc);
        chk("latency_1", vc - fc, 4);
        chk("cap_1", int'(bin_cap), 200);
        @(negedge clk);
        chk("cap_valid_drop", int'(cap_valid), 0);

        wait_trig_rise(r_now);
        chk("period_2", r_now - r_prev, 400);
        r_prev = r_now;
        trig_len(len);
        chk("trig_len_2", len, 4);
        model_sample(155);
        pulse_echo(10, 155, fc);
        wait_cap(vc);
        chk("cap_2", int'(bin_cap), 175);

        wait_trig_rise(r_now);
        chk("period_3", r_now - r_prev, 400);
        r_prev = r_now;
        trig_len(len);
        model_sample(280);
        pulse_echo(10, 280, fc);
        wait_cap(vc);
        chk("cap_3_saturated", int'(bin_cap), 125);

        wait_trig_rise(r_now);
        chk("period_4", r_now - r_prev, 400);
        r_prev = r_now;
        trig_len(len);
        fc = cyc;
        wait_fault(vc);
        chk("no_echo_fault_time", vc - fc, 21);
        chk("cap_after_fault", int'(bin_cap), 125);

        wait_trig_rise(r_now);
        chk("period_5", r_now - r_prev, 400);
        chk("fault_sticky", int'(sensor_fault), 1);
        r_prev = r_now;
        trig_len(len);
        model_sample(105);
        pulse_echo(10, 105, fc);
        wait_cap(vc);
        chk("cap_5", int'(bin_cap), 112);
        chk("fault_cleared", int'(sensor_fault), 0);

        wait_trig_rise(r_now);
        chk("period_6", r_now - r_prev, 400);
        r_prev = r_now;
        trig_len(len);
        repeat (5) @(negedge clk);
        echo = 1'b1;
        fc = cyc;
        wait_fault(vc);
        chk("stuck_fault_time", vc - fc, 302);
        echo = 1'b0;
        wait_trig_rise(r_now);
        chk("period_after_stuck", r_now - r_prev, 400);
        chk("fault_held", int'(sensor_fault), 1);
        chk("cap_held", int'(bin_cap), 112);

        trig_len(len);
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        echo = 1'b0;
        chk("midrst_trig", int'(trig), 0);
        chk("midrst_bin_cap", int'(bin_cap), 0);
        chk("midrst_cap_valid", int'(cap_valid), 0);
        chk("midrst_fault", int'(sensor_fault), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("trig_after_rst2", int'(trig), 1);
        trig_len(len);
        model_sample(125);
        pulse_echo(10, 125, fc);
        wait_cap(vc);
        chk("cap_preload", int'(bin_cap), 130);

        enable = 1'b0;
        hi = 0;
        repeat (450) begin
            @(negedge clk);
            if (trig) hi++;
        end
        chk("disabled_no_trig", hi, 0);
        chk("model_queue_empty", m_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bin_level_sensor.md
Name: bin_level_sensor

Overview:
- Upstream front end for one waste bin's ultrasonic fill sensor (HC-SR04 class).
- Periodically fires a trigger pulse and times the echo pulse width.
- Converts the width to an 8-bit fill capacity (0 = empty, 255 = full) and smooths it with a 4-sample moving average.
- Drives one bin_cap input of the waste-management display/alarm stage; the top level instantiates it once per bin.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: trigger-to-trigger interval in cycles (60 ms at 50 MHz).
- WAIT_MAX_CYCLES, 50000: maximum cycles from trigger fall to echo rise before a fault is declared.
- ECHO_MAX_CYCLES, 1500000: maximum echo high time before a fault is declared.
- ECHO_SHIFT, 12: right shift from echo cycle count to 8-bit distance.
- Constraint: PERIOD_CYCLES > TRIG_CYCLES + WAIT_MAX_CYCLES + ECHO_MAX_CYCLES + 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = measure periodically; 0 = finish current cycle, then idle
- echo  in  1  sensor echo, asynchronous to clk
- trig  out  1  sensor trigger pulse
- bin_cap  out  8  averaged fill capacity, 0..255
- cap_valid  out  1  one-cycle strobe when bin_cap updates
- sensor_fault  out  1  sticky until next good sample; 1 = last attempt timed out

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous, active-high, rst.
- Reset values: trig=0, bin_cap=0, cap_valid=0, sensor_fault=0. Reset also sets state=IDLE, clears all counters and the average history, and sets primed=0.
- rst asserted mid-measurement aborts immediately; no cap_valid is produced for the aborted cycle.
- echo passes through a 2-flop synchronizer; echo_s is 2 cycles late. All echo timing uses echo_s.
- Period counter: reset to 0 on entry to TRIG; increments every cycle; saturates at PERIOD_CYCLES.
- IDLE:
  - Go to TRIG when enable=1 and either the period counter reached PERIOD_CYCLES or primed=0.
  - After reset with enable=1, the first trigger starts in the cycle after rst deasserts.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE.
- WAIT_RISE:
  - echo_s=1: clear echo_cnt, go to MEASURE.
  - After WAIT_MAX_CYCLES cycles with no rise: fault, go to IDLE.
- MEASURE:
  - echo_cnt increments each cycle echo_s=1; it is 24 bits and saturating.
  - echo_s falls: go to CONVERT.
  - echo_cnt reaches ECHO_MAX_CYCLES: fault, go to IDLE.
- CONVERT (one cycle):
  - dist = echo_cnt >> ECHO_SHIFT, saturated to 255.
  - raw = 255 - dist.
  - If primed=0, preload all 4 history entries with raw and set primed=1; otherwise shift raw into the history, discarding the oldest entry.
  - Go to OUTPUT.
- OUTPUT (one cycle):
  - bin_cap = (h0+h1+h2+h3) >> 2, truncating; the sum is 10 bits.
  - cap_valid=1 for this cycle only; sensor_fault clears to 0.
  - Go to IDLE.
- Latency: cap_valid asserts 4 cycles after the raw echo pin falls (2 synchronizer + CONVERT + OUTPUT).
- Fault paths: sensor_fault=1; bin_cap, history and primed are held; no cap_valid.
- enable=0 in any active state: the current cycle completes normally; the block then stays in IDLE.
- echo already high on entry to WAIT_RISE: counts as an immediate rise.
- echo glitch during IDLE or TRIG: ignored.

Decomposition:
- Shared package (waste_pkg) holds:
  - state enum: IDLE, TRIG, WAIT_RISE, MEASURE, CONVERT, OUTPUT;
  - CAP_W=8;
  - CAP_FULL=8'd255.
- One sub-module, level_avg4: 4-entry history, preload on first sample, 10-bit sum, >>2. Handles the CONVERT/OUTPUT datapath.
- Synchronizer and FSM stay inline.

Test Plan:
- All tests use TRIG_CYCLES=4, PERIOD_CYCLES=400, WAIT_MAX_CYCLES=20, ECHO_MAX_CYCLES=300, ECHO_SHIFT=0.
- Reset, then enable=1 -> trig high exactly 4 cycles starting 1 cycle after rst falls. Echo 10 cycles later, high 55 cycles -> raw 200, bin_cap=200, cap_valid one pulse 4 cycles after echo falls.
- Second sample with echo high 155 cycles -> raw 100; bin_cap=(200+200+200+100)>>2=175. Next trig rises exactly 400 cycles after the previous trig rise.
- Echo high 280 cycles -> dist saturates at 255, raw=0; bin_cap updates toward 0 (175 -> 125 after history {200,200,100,0}).
- No echo after trigger -> sensor_fault=1 21 cycles after trig falls; bin_cap unchanged; no cap_valid. The next good sample clears sensor_fault.
- Echo stuck high > 300 cycles -> sensor_fault=1, FSM back in IDLE; the next trigger still fires on period.
- rst pulsed mid-MEASURE -> all outputs 0 next cycle. The first post-reset sample preloads history, so bin_cap equals that sample's raw value.
